// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: header-tagged byte FIFO with read-side packet length tracking.
// Optional sticky overflow/underflow flags are enabled by defining ROUTER_FIFO_ERR_EN.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soft_rst,
  input  logic          we,
  input  logic          re,
  input  logic          lfd_state,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          pkt_busy
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic          ovf_err,
  output logic          udf_err
`endif
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [6:0]  pkt_cnt;
  logic        clr_pend;
  logic        wr_ok;
  logic        rd_ok;
  logic        flush;
  logic [DW:0] rd_word;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok    = we && !full;
  assign rd_ok    = re && !empty;
  assign flush    = rst || soft_rst;
  assign rd_word  = mem[rd_ptr[AW-1:0]];
  assign pkt_busy = (pkt_cnt != '0);

  always_ff @(posedge clk) begin
    if (!flush && wr_ok)
      mem[wr_ptr[AW-1:0]] <= {lfd_state, din};
  end

  // clr_pend remembers that the parity byte just left, so dout returns to zero
  // one cycle later unless a new read overwrites it first.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      dout     <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= rd_word[DW-1:0];
        if (rd_word[DW]) begin
          pkt_cnt  <= 7'(rd_word[DW-1:2]) + 7'd1;
          clr_pend <= 1'b0;
        end else if (pkt_cnt != '0) begin
          pkt_cnt  <= pkt_cnt - 7'd1;
          clr_pend <= (pkt_cnt == 7'd1);
        end else begin
          clr_pend <= 1'b0;
        end
      end else if (clr_pend) begin
        dout     <= '0;
        clr_pend <= 1'b0;
      end
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (flush) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (we && full)
        ovf_err <= 1'b1;
      if (re && empty)
        udf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router. One instance per port, three in total.
- Sits directly downstream of the synchronizer. It consumes one bit of the synchronizer's one-hot write-enable and that port's soft-reset. It also returns the full/empty status the synchronizer uses for fifofull and vldout.
- Stores packet bytes tagged with a header marker. Tracks the remaining packet length on the read side, so the reader can tell when the last (parity) byte has been popped.

Parameters:
- DEPTH, 16, number of entries; power of two.
- AW, 4, pointer address width; log2(DEPTH).
- DW, 8, data byte width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- soft_rst  input  1  synchronous, active-high flush from the synchronizer (read timeout).
- we  input  1  write enable, one bit of the synchronizer's we[2:0].
- re  input  1  read enable from the destination reader.
- lfd_state  input  1  high for the header byte being written (load-first-data).
- din  input  DW  byte to write.
- dout  output  DW  registered read data.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when no entries are stored.
- pkt_busy  output  1  high while bytes of the current packet remain to be read.

Behaviour:
- Storage: DEPTH x (DW+1) array; bit DW is the header tag. A write stores {lfd_state, din}.
- Pointers: wr_ptr and rd_ptr are each AW+1 bits.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ and low AW bits equal).
  - Both flags are combinational from the registered pointers.
- Write: accepted when we=1 and full=0; the word goes to mem[wr_ptr[AW-1:0]] and wr_ptr increments. A write while full is dropped; no pointer change.
- Read: accepted when re=1 and empty=0. dout <= mem[rd_ptr] data bits, rd_ptr increments; dout is valid the cycle after re. A read while empty is ignored and dout holds.
- Simultaneous re and we:
  - Each is judged against the pre-edge flags.
  - At full, only the read occurs.
  - At empty, only the write occurs.
  - Otherwise both occur and occupancy is unchanged.
- Pointer wrap: natural modulo 2^(AW+1); no special case.
- Packet counter: pkt_cnt, 7 bits.
  - On an accepted read of a tagged word: pkt_cnt <= din-field[DW-1:2] + 1 (payload length plus parity; the header itself is not counted).
  - On an accepted read of an untagged word with pkt_cnt != 0: pkt_cnt decrements.
  - pkt_busy = (pkt_cnt != 0).
- dout clearing: when the read that takes pkt_cnt from 1 to 0 completes, dout is driven 0 one cycle later unless another read is accepted that cycle. There is no tri-state.
- Reset (rst=1): both pointers 0, pkt_cnt 0, dout 0, so empty=1, full=0, pkt_busy=0. rst overrides all activity, including mid-packet; array contents are don't-care.
- Soft reset (soft_rst=1): same effect as rst on pointers, pkt_cnt and dout. Any we/re in that cycle is ignored. rst has priority if both are asserted.

Optional Feature:
- Macro ROUTER_FIFO_ERR_EN.
- With the macro defined:
  - Adds outputs ovf_err and udf_err, 1 bit each, sticky.
  - ovf_err sets on we=1 while full=1; udf_err sets on re=1 while empty=1.
  - Both are cleared by rst or soft_rst.
- Without the macro: the ports and logic are absent; dropped writes and ignored reads are silent.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, dout=8'h00, pkt_busy=0.
- Write header 8'h0C (lfd_state=1, length 3) then bytes 8'hA1, 8'hA2, 8'hA3 and parity 8'h55. Read 5 times -> dout sequence 0C, A1, A2, A3, 55. pkt_busy goes 1 after the first read and 0 after the fifth. dout=00 the cycle after, empty=1.
- Write 16 bytes 8'h00..8'h0F -> full=1. A 17th write of 8'hFF is dropped (ovf_err=1 with ROUTER_FIFO_ERR_EN). Reading 16 bytes returns 00..0F in order.
- At full, assert re and we together with din=8'hEE -> occupancy drops to 15 and 8'hEE is never read back. At empty, assert both with din=8'h77 -> occupancy becomes 1 and the next read returns 77.
- Write 5 bytes, read 2, pulse soft_rst mid-packet -> the next cycle empty=1, pkt_busy=0, dout=00. A following write/read of 8'h3C returns 3C.
- Run 40 writes and 40 interleaved reads to force pointer wrap -> data order preserved, and full never asserts with occupancy below 16.
